// File: rtl/vmask_gen_pkg.sv
// Shared vALU definitions for the byte-lane mask generator: element-width codes,
// controller states and the elements-per-beat lookup.
package vmask_gen_pkg;

    typedef enum logic [1:0] {
        SEW_8  = 2'd0,
        SEW_16 = 2'd1,
        SEW_32 = 2'd2,
        SEW_64 = 2'd3
    } sew_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Elements carried by one beat: the beat's byte lanes divided by the element size.
    function automatic int elems_per_beat(input int lanes, input logic [1:0] sew);
        return lanes >> sew;
    endfunction

endpackage

// File: rtl/vmask_expand.sv
// Combinational fan-out of per-element enables onto byte lanes; each enabled
// element k drives lanes k*2^sew .. (k+1)*2^sew-1.
module vmask_expand
    import vmask_gen_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic [LANES-1:0] elem_en,
    input  sew_e             sew,
    output logic [LANES-1:0] lane_en
);

    always_comb begin
        lane_en = '0;
        for (int j = 0; j < LANES; j++) begin
            unique case (sew)
                SEW_8:   lane_en[j] = elem_en[j];
                SEW_16:  lane_en[j] = elem_en[j / 2];
                SEW_32:  lane_en[j] = elem_en[j / 4];
                SEW_64:  lane_en[j] = elem_en[j / 8];
            endcase
        end
    end

endmodule

// File: rtl/vmask_gen.sv
// Vector mask sequencer: accepts (vl, sew, vm) and emits one registered
// byte-lane enable mask per beat until vl elements have been covered.
module vmask_gen
    import vmask_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int SEW_WIDTH  = 2,
    parameter int VL_WIDTH   = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_req_valid,
    output logic                    in_req_ready,
    input  logic [VL_WIDTH-1:0]     in_vl,
    input  logic [SEW_WIDTH-1:0]    in_sew,
    input  logic                    in_vm,
    input  logic [DATA_WIDTH/8-1:0] in_v0,
    input  logic                    in_v0_valid,
    output logic                    in_v0_ready,
    output logic [DATA_WIDTH/8-1:0] out_m0,
    output logic                    out_valid,
    output logic                    out_start,
    output logic                    out_end
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int CW    = VL_WIDTH + 1;

    state_e                state;
    logic [VL_WIDTH-1:0]   vl_q;
    logic [SEW_WIDTH-1:0]  sew_q;
    logic                  vm_q;
    logic [CW-1:0]         idx;

    logic [CW-1:0]         vl_ext;
    logic [CW-1:0]         e_beat;
    logic [CW-1:0]         idx_next;
    logic                  is_last;
    logic                  fire;
    logic [LANES-1:0]      elem_en;
    logic [LANES-1:0]      lane_en;

    assign in_req_ready = (state == IDLE);

    // One extra counter bit keeps idx+E from wrapping at the largest vl.
    always_comb begin
        vl_ext   = {1'b0, vl_q};
        e_beat   = CW'(elems_per_beat(LANES, sew_q[1:0]));
        idx_next = idx + e_beat;
        is_last  = (idx_next >= vl_ext);
        fire     = (state == RUN) && (vm_q || in_v0_valid || (vl_q == '0));
        elem_en  = '0;
        for (int k = 0; k < LANES; k++) begin
            elem_en[k] = ((idx + CW'(k)) < vl_ext) && (vm_q || in_v0[k]);
        end
    end

    vmask_expand #(
        .LANES (LANES)
    ) u_expand (
        .elem_en (elem_en),
        .sew     (sew_e'(sew_q[1:0])),
        .lane_en (lane_en)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            vl_q        <= '0;
            sew_q       <= '0;
            vm_q        <= 1'b0;
            out_valid   <= 1'b0;
            out_start   <= 1'b0;
            out_end     <= 1'b0;
            out_m0      <= '0;
            in_v0_ready <= 1'b0;
        end else begin
            out_valid   <= fire;
            in_v0_ready <= fire && !vm_q;
            out_start   <= fire && (idx == '0);
            out_end     <= fire && is_last;
            out_m0      <= fire ? lane_en : '0;

            case (state)
                IDLE: begin
                    if (in_req_valid) begin
                        vl_q  <= in_vl;
                        sew_q <= in_sew;
                        vm_q  <= in_vm;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (fire) begin
                        idx <= idx_next;
                        if (is_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vmask_gen.sv
// Directed self-checking bench for vmask_gen using hand-computed beat masks.
module tb_vmask_gen;

    logic        clk;
    logic        rst;
    logic        in_req_valid;
    logic        in_req_ready;
    logic [10:0] in_vl;
    logic [1:0]  in_sew;
    logic        in_vm;
    logic [7:0]  in_v0;
    logic        in_v0_valid;
    logic        in_v0_ready;
    logic [7:0]  out_m0;
    logic        out_valid;
    logic        out_start;
    logic        out_end;

    int tests_run    = 0;
    int tests_failed = 0;

    vmask_gen #(
        .DATA_WIDTH (64),
        .SEW_WIDTH  (2),
        .VL_WIDTH   (11)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_req_valid (in_req_valid),
        .in_req_ready (in_req_ready),
        .in_vl        (in_vl),
        .in_sew       (in_sew),
        .in_vm        (in_vm),
        .in_v0        (in_v0),
        .in_v0_valid  (in_v0_valid),
        .in_v0_ready  (in_v0_ready),
        .out_m0       (out_m0),
        .out_valid    (out_valid),
        .out_start    (out_start),
        .out_end      (out_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [11:0] beatBits();
        return {out_valid, in_v0_ready, out_start, out_end, out_m0};
    endfunction

    task automatic expectBeat(input string tag, input logic v0r, input logic s,
                              input logic e, input logic [7:0] m0);
        checkOutput(tag, 32'(beatBits()), 32'({1'b1, v0r, s, e, m0}));
    endtask

    // Drives one request for a single cycle; returns on the negedge after acceptance.
    task automatic applyStimulus(input logic [10:0] vl, input logic [1:0] sew,
                                 input logic vm);
        @(negedge clk);
        in_req_valid = 1'b1;
        in_vl        = vl;
        in_sew       = sew;
        in_vm        = vm;
        @(negedge clk);
        in_req_valid = 1'b0;
    endtask

    task automatic waitBeat(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        if (!out_valid) checkOutput({tag, " timeout"}, 32'd0, 32'd1);
    endtask

    task automatic checkIdle(input string tag);
        @(negedge clk);
        checkOutput(tag, 32'({in_req_ready, out_valid}), 32'h2);
    endtask

    initial begin
        logic seen;
        rst          = 1'b0;
        in_req_valid = 1'b0;
        in_vl        = '0;
        in_sew       = '0;
        in_vm        = 1'b0;
        in_v0        = '0;
        in_v0_valid  = 1'b0;

        @(negedge clk);
        checkOutput("reset state", 32'({in_req_ready, beatBits()}), 32'h1000);
        rst = 1'b1;

        applyStimulus(11'd8, 2'd0, 1'b1);
        waitBeat("vl8");
        expectBeat("vl8 sew8 beat", 1'b0, 1'b1, 1'b1, 8'hFF);
        checkIdle("vl8 idle");

        applyStimulus(11'd5, 2'd1, 1'b1);
        waitBeat("vl5");
        expectBeat("vl5 sew16 beat1", 1'b0, 1'b1, 1'b0, 8'hFF);
        @(negedge clk);
        expectBeat("vl5 sew16 beat2", 1'b0, 1'b0, 1'b1, 8'h03);
        checkIdle("vl5 idle");

        applyStimulus(11'd3, 2'd2, 1'b0);
        in_v0       = 8'h02;
        in_v0_valid = 1'b1;
        @(negedge clk);
        expectBeat("vl3 sew32 beat1", 1'b1, 1'b1, 1'b0, 8'hF0);
        in_v0 = 8'h01;
        @(negedge clk);
        expectBeat("vl3 sew32 beat2", 1'b1, 1'b0, 1'b1, 8'h0F);
        in_v0_valid = 1'b0;
        in_v0       = 8'h00;
        checkIdle("vl3 idle");

        applyStimulus(11'd2, 2'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("sew64 stall", 32'({out_valid, in_v0_ready}), 32'h0);
        end
        in_v0       = 8'h01;
        in_v0_valid = 1'b1;
        @(negedge clk);
        expectBeat("vl2 sew64 beat1", 1'b1, 1'b1, 1'b0, 8'hFF);
        @(negedge clk);
        expectBeat("vl2 sew64 beat2", 1'b1, 1'b0, 1'b1, 8'hFF);
        in_v0_valid = 1'b0;
        in_v0       = 8'h00;
        checkIdle("vl2 idle");

        // Elements 6 and 7 lie beyond vl and must stay off despite their v0 bits.
        applyStimulus(11'd6, 2'd0, 1'b0);
        in_v0       = 8'hED;
        in_v0_valid = 1'b1;
        @(negedge clk);
        expectBeat("vl6 sew8 masked", 1'b1, 1'b1, 1'b1, 8'h2D);
        in_v0_valid = 1'b0;
        in_v0       = 8'h00;
        checkIdle("vl6 idle");

        applyStimulus(11'd0, 2'd0, 1'b1);
        waitBeat("vl0 vm1");
        expectBeat("vl0 vm1 beat", 1'b0, 1'b1, 1'b1, 8'h00);
        checkIdle("vl0 vm1 idle");

        applyStimulus(11'd0, 2'd1, 1'b0);
        @(negedge clk);
        expectBeat("vl0 vm0 no wait", 1'b1, 1'b1, 1'b1, 8'h00);
        checkIdle("vl0 vm0 idle");

        // Request held high through RUN: the changed vl must be ignored until the end beat.
        @(negedge clk);
        in_req_valid = 1'b1;
        in_vl        = 11'd16;
        in_sew       = 2'd0;
        in_vm        = 1'b1;
        @(negedge clk);
        in_vl = 11'd4;
        @(negedge clk);
        checkOutput("b2b beat1", 32'({in_req_ready, beatBits()}),
                    32'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF}));
        @(negedge clk);
        checkOutput("b2b beat2", 32'({in_req_ready, beatBits()}),
                    32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF}));
        @(negedge clk);
        in_req_valid = 1'b0;
        checkOutput("b2b gap", 32'({in_req_ready, out_valid}), 32'h0);
        @(negedge clk);
        expectBeat("b2b second req", 1'b0, 1'b1, 1'b1, 8'h0F);
        checkIdle("b2b idle");

        applyStimulus(11'd32, 2'd0, 1'b1);
        @(negedge clk);
        expectBeat("abort beat1", 1'b0, 1'b1, 1'b0, 8'hFF);
        @(negedge clk);
        expectBeat("abort beat2", 1'b0, 1'b0, 1'b0, 8'hFF);
        rst = 1'b0;
        #1;
        checkOutput("abort reset", 32'({in_req_ready, beatBits()}), 32'h1000);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("abort no resume", 32'(seen), 32'd0);

        applyStimulus(11'd16, 2'd1, 1'b1);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            expectBeat("post-reset vl16", 1'b0, (b == 0), (b == 3), 8'hFF);
        end
        checkIdle("post-reset idle");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vmask_gen.md
VMASK_GEN -- requirements
Module: vmask_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 64, shall set the width of one data beat in bits; byte lanes per beat = DATA_WIDTH/8 (8 at default).
REQ-002 Parameter SEW_WIDTH, default 2, shall set the width of the element-width code (0=8b, 1=16b, 2=32b, 3=64b).
REQ-003 Parameter VL_WIDTH, default 11, shall set the width of the vector-length field.
REQ-004 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  shall be the reset: asynchronous, active-low.
REQ-006 in_req_valid  input  1  shall request a new mask sequence.
REQ-007 in_req_ready  output  1  shall be high only in IDLE; a request is accepted when in_req_valid and in_req_ready are both high.
REQ-008 in_vl  input  VL_WIDTH  shall give the element count, sampled on acceptance.
REQ-009 in_sew  input  SEW_WIDTH  shall give the element width, sampled on acceptance.
REQ-010 in_vm  input  1  shall mean unmasked (1) or v0-masked (0), sampled on acceptance.
REQ-011 in_v0  input  8  shall carry v0 bits for the current beat, bit k for beat element k.
REQ-012 in_v0_valid  input  1  shall qualify in_v0; ignored when the latched vm=1.
REQ-013 in_v0_ready  output  1  shall pulse high in every cycle a beat is emitted with latched vm=0.
REQ-014 out_m0  output  8  shall carry the byte-lane enable mask, one bit per byte lane.
REQ-015 out_valid, out_start, out_end  output  1 each  shall flag a valid beat, the first beat of a sequence, and the last beat of a sequence.

Function
REQ-016 States shall be IDLE and RUN; acceptance moves IDLE->RUN, emission of the beat with out_end=1 moves RUN->IDLE.
REQ-017 Elements per beat shall be E = 8 >> sew; beat count shall be ceil(vl/E).
REQ-018 An element index counter shall start at 0 on acceptance and advance by E on each emitted beat.
REQ-019 In RUN a beat shall be emitted in any cycle where latched vm=1, or latched vm=0 and in_v0_valid=1; otherwise out_valid shall be 0 and the counter shall hold.
REQ-020 Beat element k shall be enabled iff (idx+k) < vl and (vm=1 or in_v0[k]=1).
REQ-021 An enabled element k shall set byte lanes k*2^sew through (k+1)*2^sew-1 of out_m0; all other lanes shall be 0.
REQ-022 All outputs shall be registered; the first beat shall appear no earlier than the cycle after acceptance.
REQ-023 out_end shall be set on the beat where idx+E >= vl; out_start and out_end shall both be set on a single-beat sequence.
REQ-024 vl=0 shall emit exactly one beat with out_m0=0 and out_start=out_end=1, without waiting for in_v0_valid.
REQ-025 A request with in_req_ready=0 shall be ignored; requests may be accepted back-to-back, re-entering RUN from the end-beat cycle.
REQ-026 When out_valid=0, out_m0, out_start and out_end shall be 0.
REQ-027 Counter arithmetic shall be VL_WIDTH+1 bits so idx+E cannot wrap at the maximum vl.

Reset
REQ-028 Reset assertion shall force IDLE and clear the counter, the latched vl/sew/vm and all outputs to 0 (in_req_ready=1 after reset), including mid-sequence; the aborted sequence shall not resume.

Structure
REQ-029 SEW encodings, the state enum and the E lookup shall live in the shared vALU package.
REQ-030 One sub-module, vmask_expand (combinational element-bit to byte-lane expansion by sew), is natural; all other logic shall be in vmask_gen.

Verification
REQ-031 vl=8, sew=0, vm=1 -> one beat, out_m0=0xFF, start=end=1.
REQ-032 vl=5, sew=1, vm=1 -> beats 0xFF, 0x03; start on beat 1, end on beat 2.
REQ-033 vl=3, sew=2, vm=0, in_v0=0x2 then 0x1 -> beats 0xF0, 0x0F; in_v0_ready pulses twice.
REQ-034 vl=2, sew=3, vm=0, in_v0_valid low for 3 cycles -> no beats while low, then 0xFF per valid v0 bit.
REQ-035 vl=0 -> single beat, out_m0=0x00, start=end=1.
REQ-036 rst low during beat 2 of a vl=32, sew=0 sequence -> all outputs 0 next cycle, in_req_ready=1, no further beats.
